// File: rtl/bht_predictor_pkg.sv
// Purpose : shared encodings for the branch history table (op codes, counter states, widths).
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package bht_predictor_pkg;

  // Instruction memory word-address width (PC is a word address).
  localparam int IM_ADDR_NBIT = 8;

  // Table operation requested by the pipeline interface controller.
  localparam int BHT_OP_NBIT = 2;
  localparam logic [BHT_OP_NBIT-1:0] BHT_OP_NOP = 2'd0;
  localparam logic [BHT_OP_NBIT-1:0] BHT_OP_SET = 2'd1;
  localparam logic [BHT_OP_NBIT-1:0] BHT_OP_INC = 2'd2;
  localparam logic [BHT_OP_NBIT-1:0] BHT_OP_DEC = 2'd3;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  localparam logic [1:0] BHT_CTR_SNT = 2'b00;
  localparam logic [1:0] BHT_CTR_WNT = 2'b01;
  localparam logic [1:0] BHT_CTR_WT  = 2'b10;
  localparam logic [1:0] BHT_CTR_ST  = 2'b11;

endpackage

// File: rtl/bht_predictor_sat_ctr2.sv
// Purpose : 2-bit saturating increment/decrement of a branch counter.
// Latency : combinational, 0 cycles.
// Backpr. : none; pure function of its inputs.
// Ports   : ctr (current state), inc/dec (step request), ctr_nxt (next state).
module sat_ctr2
  import bht_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    if (inc && !dec) begin
      if (ctr != BHT_CTR_ST) ctr_nxt = ctr + 2'd1;
    end else if (dec && !inc) begin
      if (ctr != BHT_CTR_SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/bht_predictor.sv
// Purpose : direct-mapped branch history table; IF-side lookup, EX-side training, hit/miss stats.
// Latency : lookup 0 cycles from registered state; updates visible the following cycle.
// Backpr. : none; one lookup and one update accepted every cycle.
// Ports   : clk/rst (sync active-high); if_pc -> pred_take/pred_target;
//           bht_op/ex_pc/ex_wtg_pc_new train the table; dbp_hit/dbp_miss -> stat_hit/stat_miss.
module bht_predictor
  import bht_predictor_pkg::*;
#(
  parameter int ADDR_NBIT = IM_ADDR_NBIT,
  parameter int IDX_NBIT  = 4,
  parameter int STAT_NBIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_NBIT-1:0]   if_pc,
  output logic                   pred_take,
  output logic [ADDR_NBIT-1:0]   pred_target,
  input  logic [BHT_OP_NBIT-1:0] bht_op,
  input  logic [ADDR_NBIT-1:0]   ex_pc,
  input  logic [ADDR_NBIT-1:0]   ex_wtg_pc_new,
  input  logic                   dbp_hit,
  input  logic                   dbp_miss,
  output logic [STAT_NBIT-1:0]   stat_hit,
  output logic [STAT_NBIT-1:0]   stat_miss
);

  localparam int ENTRIES  = 1 << IDX_NBIT;
  localparam int TAG_NBIT = ADDR_NBIT - IDX_NBIT;

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_NBIT-1:0]  tag_q    [ENTRIES];
  logic [ADDR_NBIT-1:0] target_q [ENTRIES];
  logic [1:0]           ctr_q    [ENTRIES];

  // ---------------- IF-side lookup ----------------
  logic [IDX_NBIT-1:0] if_idx;
  logic [TAG_NBIT-1:0] if_tag;
  logic                if_hit;

  assign if_idx      = if_pc[IDX_NBIT-1:0];
  assign if_tag      = if_pc[ADDR_NBIT-1:IDX_NBIT];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_take   = if_hit && ctr_q[if_idx][1];
  // Target is exposed on any valid entry, even on a tag mismatch; pred_take gates its use.
  assign pred_target = valid_q[if_idx] ? target_q[if_idx] : '0;

  // ---------------- EX-side write path ----------------
  logic [IDX_NBIT-1:0]  ex_idx;
  logic [TAG_NBIT-1:0]  ex_tag;
  logic                 ex_hit;
  logic [1:0]           ex_ctr_step;

  logic                 wr_en;
  logic [TAG_NBIT-1:0]  wr_tag;
  logic [ADDR_NBIT-1:0] wr_target;
  logic [1:0]           wr_ctr;

  assign ex_idx = ex_pc[IDX_NBIT-1:0];
  assign ex_tag = ex_pc[ADDR_NBIT-1:IDX_NBIT];
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Only one write port, so a single counter stepper serves the whole table.
  sat_ctr2 u_sat_ctr2 (
    .ctr     (ctr_q[ex_idx]),
    .inc     (bht_op == BHT_OP_INC),
    .dec     (bht_op == BHT_OP_DEC),
    .ctr_nxt (ex_ctr_step)
  );

  always_comb begin
    wr_en     = 1'b0;
    wr_tag    = ex_tag;
    wr_target = ex_wtg_pc_new;
    wr_ctr    = ctr_q[ex_idx];
    case (bht_op)
      BHT_OP_SET: begin
        wr_en  = 1'b1;
        wr_ctr = BHT_CTR_ST;
      end
      BHT_OP_INC: begin
        wr_en  = 1'b1;
        // A miss replaces whatever lives at this index with a weakly-taken entry.
        wr_ctr = ex_hit ? ex_ctr_step : BHT_CTR_WT;
      end
      BHT_OP_DEC: begin
        // Not-taken never allocates; on a hit only the counter moves.
        wr_en     = ex_hit;
        wr_target = target_q[ex_idx];
        wr_ctr    = ex_ctr_step;
      end
      default: wr_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= BHT_CTR_SNT;
      end
    end else if (wr_en) begin
      valid_q[ex_idx]  <= 1'b1;
      tag_q[ex_idx]    <= wr_tag;
      target_q[ex_idx] <= wr_target;
      ctr_q[ex_idx]    <= wr_ctr;
    end
  end

  // ---------------- Statistics ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit  <= '0;
      stat_miss <= '0;
    end else begin
      if (dbp_hit && (stat_hit != '1))   stat_hit  <= stat_hit + 1'b1;
      if (dbp_miss && (stat_miss != '1)) stat_miss <= stat_miss + 1'b1;
    end
  end

endmodule
